// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
//   SEG_NUM_DIGITS  number of display positions / frame-buffer entries
//   SEG_CODE_BLANK  digit code that renders all segments off
//   SEG_CODE_DASH   digit code that renders a centre dash
//   seg_entry_t     one frame-buffer entry: digit code plus decimal point
//   cnt_width()     counter width for a modulo, never below one bit
package seg_pkg;

   localparam int         SEG_NUM_DIGITS = 8;
   localparam logic [3:0] SEG_CODE_BLANK = 4'd10;
   localparam logic [3:0] SEG_CODE_DASH  = 4'd11;

   typedef struct packed {
      logic [3:0] digit;
      logic       dp;
   } seg_entry_t;

   function automatic int cnt_width(input int modulo);
      return (modulo <= 2) ? 1 : $clog2(modulo);
   endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running modulo counter with terminal-count flag.
//   clk    system clock
//   rst_n  synchronous reset, active low; clears cnt
//   en     count enable
//   cnt    current count, 0 .. MOD-1
//   tc     high while cnt == MOD-1 (the next enabled edge wraps to 0)
module tick_counter
   import seg_pkg::*;
#(
   parameter  int MOD = 2,
   localparam int W   = cnt_width(MOD)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(MOD - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexing scan controller for an 8-digit common-anode 7-segment
// display. Holds an 8-entry digit/dp frame buffer, steps through positions
// 0..7, inserts a blanking gap at the start of every digit slot and blanks
// positions selected by blink_mask during the off half of the blink period.
//   clk         system clock
//   rst_n       synchronous reset, active low
//   wr_en       frame-buffer write strobe
//   wr_addr     entry to write (= display position)
//   wr_digit    digit code to store (12-15 stored as-is)
//   wr_dp       decimal point to store, 1 = lit
//   blink_mask  bit i set: position i blinks (not stored)
//   digit       code to segment decoder
//   current_dp  dp to segment decoder
//   position    active position to segment decoder
//   frame_tick  one-cycle pulse in the first cycle position shows 0 after a wrap
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 12000,
   parameter int BLANK_CYCLES = 600,
   parameter int BLINK_CYCLES = 6000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_digit,
   input  logic       wr_dp,
   input  logic [7:0] blink_mask,
   output logic [3:0] digit,
   output logic       current_dp,
   output logic [2:0] position,
   output logic       frame_tick
);

   localparam int SW = cnt_width(DIGIT_CYCLES);
   localparam int BW = cnt_width(BLINK_CYCLES);

   logic [SW-1:0] slot_cnt;
   logic          slot_tc;
   logic [BW-1:0] blink_cnt;
   logic          blink_tc;
   logic [2:0]    pos;
   logic          blink_on;
   logic          wrap_q;
   logic          in_gap;
   logic [3:0]    next_digit;
   logic          next_dp;

   seg_entry_t fb [SEG_NUM_DIGITS];

   tick_counter #(.MOD(DIGIT_CYCLES)) u_slot_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .cnt   (slot_cnt),
      .tc    (slot_tc)
   );

   tick_counter #(.MOD(BLINK_CYCLES)) u_blink_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .cnt   (blink_cnt),
      .tc    (blink_tc)
   );

   generate
      if (BLANK_CYCLES == 0) begin : g_no_gap
         assign in_gap = 1'b0;
      end else begin : g_gap
         assign in_gap = (slot_cnt < SW'(BLANK_CYCLES));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SEG_NUM_DIGITS; i++) begin
            fb[i] <= '{digit: SEG_CODE_BLANK, dp: 1'b0};
         end
      end else if (wr_en) begin
         fb[wr_addr] <= '{digit: wr_digit, dp: wr_dp};
      end
   end

   // The output stage is one clock behind pos/slot_cnt, so the wrap flag is
   // delayed one extra stage to line frame_tick up with position == 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos      <= '0;
         blink_on <= 1'b1;
         wrap_q   <= 1'b0;
      end else begin
         if (slot_tc) begin
            pos <= pos + 3'd1;
         end
         if (blink_tc) begin
            blink_on <= ~blink_on;
         end
         wrap_q <= slot_tc && (pos == 3'd7);
      end
   end

   // Reads the pre-edge buffer, so a same-cycle write to this entry shows next cycle.
   always_comb begin
      next_digit = SEG_CODE_BLANK;
      next_dp    = 1'b0;
      if (!in_gap && !(!blink_on && blink_mask[pos])) begin
         next_digit = fb[pos].digit;
         next_dp    = fb[pos].dp;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit      <= SEG_CODE_BLANK;
         current_dp <= 1'b0;
         position   <= '0;
         frame_tick <= 1'b0;
      end else begin
         digit      <= next_digit;
         current_dp <= next_dp;
         position   <= pos;
         frame_tick <= wrap_q;
      end
   end

endmodule
